seg_scan4: RTL and testbench

Four-digit seven-segment scan driver for the counter9999 display path. It sits directly downstream of the 2^16 clock divider and consumes its 3-bit tap bus `clk_480` as a synchronous scan phase. It does not use that bus as a clock. Each frame it latches a 4-digit BCD value, applies optional leading-zero blanking, and drives active-low anodes, segments and decimal point. A blanking slot precedes every digit to suppress ghosting.

---
 rtl/seg_scan4.sv | 133 +++++++++++++
 tb/tb_seg_scan4.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan4.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan4
//  Description : Four-digit seven-segment scan driver. Uses the divider tap
//                bus clk_480 as a synchronous scan phase, latches a BCD frame
//                at each 7->0 wrap, applies optional leading-zero blanking and
//                drives active-low anodes, segments and decimal point with a
//                blanking slot in front of every digit.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan4 (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  clk_480,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam logic [3:0] c_AN_OFF    = 4'b1111;
    localparam logic [6:0] c_SEG_OFF   = 7'h7F;
    localparam logic [6:0] c_SEG_DASH  = 7'h3F;
    localparam logic [2:0] c_SCAN_LAST = 3'b111;
    localparam logic [2:0] c_SCAN_FIRST = 3'b000;

    // Two-stage scan history: scan_cur_q is the current scan phase,
    // scan_prev_q the one before it; together they detect the frame wrap.
    logic [2:0]  scan_cur_q;
    logic [2:0]  scan_prev_q;
    logic [15:0] frame_q;
    logic [3:0]  dp_frame_q;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic        tick_q;

    logic [3:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;

    logic        w_wrap;
    logic [1:0]  w_slot;
    logic        w_phase;
    logic [3:0]  w_digit;
    logic [3:0]  w_zero;
    logic [3:0]  w_blank;

    // Active-low {g,f,e,d,c,b,a}; codes 10..15 show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = c_SEG_DASH;
        endcase
        return s;
    endfunction

    assign w_wrap  = (scan_prev_q == c_SCAN_LAST) && (scan_cur_q == c_SCAN_FIRST);
    assign w_slot  = scan_cur_q[2:1];
    assign w_phase = scan_cur_q[0];
    assign w_digit = frame_q[{w_slot, 2'b00} +: 4];

    // Per-digit zero flags; an invalid code is nonzero so it is never blanked.
    genvar k;
    generate
        for (k = 0; k < 4; k = k + 1) begin : g_zero
            assign w_zero[k] = (frame_q[4*k +: 4] == 4'd0);
        end
    endgenerate

    // A digit is blanked only if it and every digit above it are zero.
    assign w_blank[3] = lz_en & w_zero[3];
    assign w_blank[2] = lz_en & w_zero[3] & w_zero[2];
    assign w_blank[1] = lz_en & w_zero[3] & w_zero[2] & w_zero[1];
    assign w_blank[0] = 1'b0;

    // Next display drive: blank in phase 0 or for a suppressed digit.
    always_comb begin
        an_d  = c_AN_OFF;
        seg_d = c_SEG_OFF;
        dp_d  = 1'b1;
        if (w_phase && !w_blank[w_slot]) begin
            an_d  = ~(4'b0001 << w_slot);
            seg_d = decode(w_digit);
            dp_d  = ~dp_frame_q[w_slot];
        end
    end

    // Scan history, frame latch on wrap and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cur_q  <= 3'd0;
            scan_prev_q <= 3'd0;
            frame_q     <= 16'h0000;
            dp_frame_q  <= 4'd0;
            an_q        <= c_AN_OFF;
            seg_q       <= c_SEG_OFF;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            scan_cur_q  <= clk_480;
            scan_prev_q <= scan_cur_q;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= w_wrap;
            if (w_wrap) begin
                frame_q    <= bcd;
                dp_frame_q <= dp_in;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan4
//  Description : Self-checking bench for seg_scan4 with a behavioural display
//                model, directed scenarios and randomized scan/BCD traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan4;

    logic        clk;
    logic        rst;
    logic [2:0]  clk_480;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    seg_scan4 dut (
        .clk        (clk),
        .rst        (rst),
        .clk_480    (clk_480),
        .bcd        (bcd),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment patterns indexed by digit value.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Model state: last two scan phases seen, the latched frame and expected outputs.
    logic [2:0]  m_h1 = 3'd0;
    logic [2:0]  m_h2 = 3'd0;
    logic [15:0] m_frame = 16'h0;
    logic [3:0]  m_dpf = 4'h0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic        e_tick = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        logic        r_s;
        logic [2:0]  c_s;
        logic [15:0] b_s;
        logic [3:0]  d_s;
        logic        l_s;
        logic        wrap;
        int          slot;
        int          upper;
        r_s = rst; c_s = clk_480; b_s = bcd; d_s = dp_in; l_s = lz_en;
        @(posedge clk);
        cyc++;
        if (r_s) begin
            m_h1 = 3'd0; m_h2 = 3'd0; m_frame = 16'h0; m_dpf = 4'h0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
        end else begin
            wrap   = (m_h2 == 3'd7) && (m_h1 == 3'd0);
            e_an   = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            e_tick = wrap;
            slot   = int'(m_h1) / 2;
            if ((int'(m_h1) % 2) == 1) begin
                upper = int'(m_frame) >> (4 * slot);
                if (!(l_s && slot > 0 && upper == 0)) begin
                    e_an  = 4'hF ^ (4'b0001 << slot);
                    e_seg = seg_tab[upper & 15];
                    e_dp  = ~m_dpf[slot];
                end
            end
            if (wrap) begin
                m_frame = b_s;
                m_dpf   = d_s;
            end
            m_h2 = m_h1;
            m_h1 = c_s;
        end
        #1;
        chk("an",   {12'h0, an},         {12'h0, e_an});
        chk("seg",  {9'h0, seg},         {9'h0, e_seg});
        chk("dp",   {15'h0, dp},         {15'h0, e_dp});
        chk("tick", {15'h0, frame_tick}, {15'h0, e_tick});
    endtask

    task automatic step(input logic [2:0] v);
        clk_480 = v;
        repeat (3) tick();
    endtask

    task automatic run_to_wrap();
        for (int v = 1; v < 8; v++) step(3'(v));
        step(3'd0);
    endtask

    initial begin
        logic [15:0] rb;
        int          r;
        int          hold;

        rst = 1'b1; clk_480 = 3'd0; bcd = 16'h1234; dp_in = 4'h0; lz_en = 1'b0;
        #2;
        tick(); tick();
        chk("rst_an",   {12'h0, an},         16'h000F);
        chk("rst_seg",  {9'h0, seg},         16'h007F);
        chk("rst_dp",   {15'h0, dp},         16'h0001);
        chk("rst_tick", {15'h0, frame_tick}, 16'h0000);
        rst = 1'b0;

        // Scan sequence with 1234
        step(3'd0);
        run_to_wrap();
        step(3'd1); chk("s0_an", {12'h0, an}, 16'h000E); chk("s0_seg", {9'h0, seg}, 16'h0019);
        step(3'd2); chk("p0_an", {12'h0, an}, 16'h000F); chk("p0_seg", {9'h0, seg}, 16'h007F);
        step(3'd3); chk("s1_an", {12'h0, an}, 16'h000D); chk("s1_seg", {9'h0, seg}, 16'h0030);
        step(3'd5); chk("s2_an", {12'h0, an}, 16'h000B); chk("s2_seg", {9'h0, seg}, 16'h0024);
        step(3'd7); chk("s3_an", {12'h0, an}, 16'h0007); chk("s3_seg", {9'h0, seg}, 16'h0079);

        // Leading zeros
        bcd = 16'h0070; lz_en = 1'b1;
        step(3'd0);
        run_to_wrap();
        step(3'd1); chk("lz_d0", {9'h0, seg}, 16'h0040);
        step(3'd3); chk("lz_d1", {9'h0, seg}, 16'h0078); chk("lz_d1an", {12'h0, an}, 16'h000D);
        step(3'd5); chk("lz_d2an", {12'h0, an}, 16'h000F);
        step(3'd7); chk("lz_d3an", {12'h0, an}, 16'h000F);
        bcd = 16'h0000;
        step(3'd0);
        step(3'd1); chk("z_d0", {9'h0, seg}, 16'h0040); chk("z_d0an", {12'h0, an}, 16'h000E);
        step(3'd3); chk("z_d1an", {12'h0, an}, 16'h000F);
        lz_en = 1'b0;
        step(3'd3); chk("nolz_d1", {9'h0, seg}, 16'h0040); chk("nolz_d1an", {12'h0, an}, 16'h000D);
        step(3'd7); chk("nolz_d3", {9'h0, seg}, 16'h0040); chk("nolz_d3an", {12'h0, an}, 16'h0007);

        // Invalid digit and decimal point
        bcd = 16'h0A05; dp_in = 4'b0100; lz_en = 1'b1;
        step(3'd0);
        run_to_wrap();
        step(3'd5); chk("inv_an", {12'h0, an}, 16'h000B); chk("inv_seg", {9'h0, seg}, 16'h003F);
        chk("inv_dp", {15'h0, dp}, 16'h0000);
        step(3'd3); chk("inv_d1", {9'h0, seg}, 16'h0040); chk("inv_d1dp", {15'h0, dp}, 16'h0001);
        step(3'd7); chk("inv_d3an", {12'h0, an}, 16'h000F);
        step(3'd1); chk("inv_d0", {9'h0, seg}, 16'h0012);

        // Tear-free latch
        bcd = 16'h1111; dp_in = 4'h0; lz_en = 1'b0;
        run_to_wrap();
        for (int v = 1; v < 5; v++) step(3'(v));
        bcd = 16'h2222;
        step(3'd5); chk("tear_d2", {9'h0, seg}, 16'h0079);
        step(3'd6);
        step(3'd7); chk("tear_d3", {9'h0, seg}, 16'h0079);
        step(3'd0);
        step(3'd1); chk("new_d0", {9'h0, seg}, 16'h0024);

        // Mid-operation reset
        bcd = 16'h5555;
        run_to_wrap();
        step(3'd1); step(3'd2); step(3'd3);
        rst = 1'b1;
        tick();
        chk("mr_an", {12'h0, an}, 16'h000F); chk("mr_seg", {9'h0, seg}, 16'h007F);
        chk("mr_tick", {15'h0, frame_tick}, 16'h0000);
        rst = 1'b0; lz_en = 1'b1;
        tick(); tick();
        chk("mr_d1an", {12'h0, an}, 16'h000F);
        step(3'd1); chk("mr_d0", {9'h0, seg}, 16'h0040); chk("mr_d0an", {12'h0, an}, 16'h000E);

        // Latency and non-wrap jump
        lz_en = 1'b0; bcd = 16'h4321;
        run_to_wrap();
        step(3'd2);
        clk_480 = 3'd3;
        tick(); chk("lat1_an", {12'h0, an}, 16'h000F);
        tick(); chk("lat2_an", {12'h0, an}, 16'h000D); chk("lat2_seg", {9'h0, seg}, 16'h0024);
        step(3'd4);
        bcd = 16'h9999;
        step(3'd0);
        step(3'd1); chk("jmp_d0", {9'h0, seg}, 16'h0079);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            if (r < 75) clk_480 = clk_480 + 3'd1;
            else        clk_480 = 3'($urandom_range(0, 7));
            if (($urandom_range(0, 3)) == 0) begin
                rb = 16'($urandom);
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 1) == 0) rb[4*k +: 4] = 4'd0;
                bcd = rb;
            end
            dp_in = 4'($urandom);
            if (($urandom_range(0, 7)) == 0) lz_en = 1'($urandom);
            hold = int'($urandom_range(1, 3));
            repeat (hold) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
